// File: rtl/i2s_audio_tx.sv
// Stereo PCM to I2S serialiser: derived BCK/LRCK, one-entry holding register, valid/ready input.
// Optional macro I2S_LEFT_JUSTIFIED_EN selects left-justified framing (no slot delay, LRCK 1 = left).
module i2s_audio_tx #(
    parameter int unsigned AUDIO_DW     = 16,
    parameter int unsigned BCK_HALF_DIV = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [AUDIO_DW-1:0] left,
    input  logic [AUDIO_DW-1:0] right,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                underrun,
    output logic                I2S_BCK,
    output logic                I2S_LRCK,
    output logic                I2S_DATA
);

    localparam int unsigned FrameW = 2 * AUDIO_DW;
    localparam int unsigned DivW   = (BCK_HALF_DIV > 1) ? $clog2(BCK_HALF_DIV) : 1;
    localparam int unsigned BitW   = $clog2(FrameW);

    localparam logic [DivW-1:0] DivLast    = DivW'(BCK_HALF_DIV - 1);
    localparam logic [BitW-1:0] BitLast    = BitW'(FrameW - 1);
    localparam logic [BitW-1:0] RightStart = BitW'(AUDIO_DW);

    logic [DivW-1:0]   div_q, div_d;
    logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [FrameW-1:0] shift_q, shift_d, shift_nx;
    logic [FrameW-1:0] hold_q, hold_d;
    logic [FrameW-1:0] last_q, last_d;
    logic              hold_full_q, hold_full_d;
    logic              bck_q, bck_d;
    logic              lrck_q, lrck_d;
    logic              data_q, data_d;
    logic              underrun_q, underrun_d;

    logic div_tc, fall_ev, frame_load, accept;

    always_comb begin
        div_tc      = (div_q == DivLast);
        fall_ev     = div_tc && bck_q;
        frame_load  = fall_ev && (bit_cnt_q == BitLast);
        accept      = sample_valid && !hold_full_q;

        div_d       = div_tc ? '0 : div_q + DivW'(1);
        bck_d       = div_tc ? ~bck_q : bck_q;
        bit_cnt_d   = bit_cnt_q;
        shift_nx    = shift_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        last_d      = last_q;
        lrck_d      = lrck_q;
        data_d      = data_q;
        underrun_d  = 1'b0;

        if (accept) begin
            hold_d      = {left, right};
            hold_full_d = 1'b1;
        end

        if (fall_ev) begin
            bit_cnt_d = (bit_cnt_q == BitLast) ? '0 : bit_cnt_q + BitW'(1);
`ifdef I2S_LEFT_JUSTIFIED_EN
            lrck_d    = (bit_cnt_d < RightStart);
`else
            lrck_d    = (bit_cnt_d >= RightStart);
`endif
            if (frame_load) begin
                // hold_full_q and accept are exclusive, so a same-clk accept stays in hold
                if (hold_full_q) begin
                    shift_nx    = hold_q;
                    last_d      = hold_q;
                    hold_full_d = 1'b0;
                end else begin
                    shift_nx    = last_q;
                    underrun_d  = 1'b1;
                end
            end else begin
                shift_nx = {shift_q[FrameW-2:0], 1'b0};
            end
            shift_d = shift_nx;
`ifdef I2S_LEFT_JUSTIFIED_EN
            data_d  = shift_nx[FrameW-1];
`else
            data_d  = shift_q[FrameW-1];
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            last_q      <= '0;
            hold_full_q <= 1'b0;
            bck_q       <= 1'b0;
            lrck_q      <= 1'b0;
            data_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            div_q       <= div_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            last_q      <= last_d;
            hold_full_q <= hold_full_d;
            bck_q       <= bck_d;
            lrck_q      <= lrck_d;
            data_q      <= data_d;
            underrun_q  <= underrun_d;
        end
    end

    assign sample_ready = !hold_full_q;
    assign underrun     = underrun_q;
    assign I2S_BCK      = bck_q;
    assign I2S_LRCK     = lrck_q;
    assign I2S_DATA     = data_q;

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Scoreboard bench for i2s_audio_tx: expected slots are queued per frame, a monitor checks each BCK fall.
module tb_i2s_audio_tx;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] left, right;
    logic        sample_valid;
    logic        sample_ready, underrun, I2S_BCK, I2S_LRCK, I2S_DATA;

    i2s_audio_tx #(
        .AUDIO_DW    (16),
        .BCK_HALF_DIV(16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .left        (left),
        .right       (right),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .underrun    (underrun),
        .I2S_BCK     (I2S_BCK),
        .I2S_LRCK    (I2S_LRCK),
        .I2S_DATA    (I2S_DATA)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic data;
        logic lrck;
        logic ur;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          stray = 0;
    int          cyc = 0;
    logic [31:0] last_pair = '0;

    // Clocks since reset release; the first posedge after release is cycle 1.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, req, cyc);
        end
    endtask

    // Queue the slots of one frame, slot k = bit_cnt value after the fall event.
    function automatic void push_slots(input logic [31:0] p, input logic [31:0] prev,
                                       input logic ur, input int kstart);
        exp_t e;
        for (int k = kstart; k < 32; k++) begin
`ifdef I2S_LEFT_JUSTIFIED_EN
            e.data = p[31-k];
            e.lrck = (k < 16);
`else
            e.data = (k == 0) ? prev[0] : p[32-k];
            e.lrck = (k >= 16);
`endif
            e.ur = (k == 0) ? ur : 1'b0;
            exp_q.push_back(e);
        end
    endfunction

    function automatic void expect_frame(input logic [31:0] p, input logic ur);
        push_slots(p, last_pair, ur, 0);
        last_pair = p;
    endfunction

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Called at a negedge; leaves sample_valid high so callers can stream pairs back to back.
    task automatic offer(input logic [31:0] pair, input int want_acc, input string name);
        int n;
        n = 0;
        left         = pair[31:16];
        right        = pair[15:0];
        sample_valid = 1'b1;
        while (!sample_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!sample_ready) begin
            total++;
            bad++;
            $display("FAIL %s: ready never rose, got 0 want 1", name);
        end else begin
            @(negedge clk);
            check({name, "_accept_cyc"}, cyc, want_acc);
            check({name, "_ready_low"}, sample_ready, 0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bck"}, I2S_BCK, 0);
        check({tag, "_lrck"}, I2S_LRCK, 0);
        check({tag, "_data"}, I2S_DATA, 0);
        check({tag, "_underrun"}, underrun, 0);
        check({tag, "_ready"}, sample_ready, 1);
    endtask

    initial begin : monitor
        logic bck_prev;
        int   last_fall;
        exp_t e;
        bck_prev  = 1'b0;
        last_fall = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                bck_prev  = 1'b0;
                last_fall = 0;
            end else begin
                if (bck_prev && !I2S_BCK) begin
                    check("bck_period", cyc - last_fall, 32);
                    last_fall = cyc;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_fall: got fall with empty queue want none");
                    end else begin
                        e = exp_q.pop_front();
                        check("data", I2S_DATA, e.data);
                        check("lrck", I2S_LRCK, e.lrck);
                        check("underrun", underrun, e.ur);
                    end
                end else if (underrun) begin
                    stray++;
                end
                bck_prev = I2S_BCK;
            end
        end
    end

    localparam logic [31:0] PairA = {16'hA5C3, 16'h8001};
    localparam logic [31:0] PairX1 = {16'h8000, 16'h0001};
    localparam logic [31:0] PairX2 = {16'h8001, 16'h0002};
    localparam logic [31:0] PairX3 = {16'h8002, 16'h0003};
    localparam logic [31:0] PairP = {16'h7FFF, 16'h0001};
    localparam logic [31:0] PairQ = {16'h12B4, 16'h5678};

    initial begin : stimulus
        int n;
        left         = '0;
        right        = '0;
        sample_valid = 1'b0;
        reset_n      = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        push_slots('0, '0, 1'b0, 1);
        expect_frame('0, 1'b1);
        #2 reset_n = 1'b1;
        wait_cyc(15);
        check("bck_before_rise", I2S_BCK, 0);
        wait_cyc(16);
        check("bck_rise", I2S_BCK, 1);

        wait_cyc(1100);
        expect_frame(PairA, 1'b0);
        offer(PairA, 1101, "pair_a");
        sample_valid = 1'b0;

        // Streamed pairs: each waits for the previous one to leave hold at a frame load.
        wait_cyc(2048);
        expect_frame(PairX1, 1'b0);
        offer(PairX1, 2049, "x1");
        expect_frame(PairX2, 1'b0);
        offer(PairX2, 3073, "x2");
        expect_frame(PairX3, 1'b0);
        offer(PairX3, 4097, "x3");
        expect_frame(PairP, 1'b0);
        offer(PairP, 5121, "pair_p");
        sample_valid = 1'b0;

        expect_frame(PairP, 1'b1);
        expect_frame(PairP, 1'b1);

        // Accept lands on the load clk of frame 9 with hold empty.
        wait_cyc(9215);
        expect_frame(PairP, 1'b1);
        expect_frame(PairQ, 1'b0);
        offer(PairQ, 9216, "load_clk_offer");
        sample_valid = 1'b0;
        expect_frame(PairQ, 1'b1);

        wait_cyc(11300);
        offer({16'hFFFF, 16'hFFFF}, 11301, "discarded");
        sample_valid = 1'b0;

        // Reset with BCK high at bit_cnt 9 of frame 11.
        wait_cyc(11572);
        check("bck_high_pre_reset", I2S_BCK, 1);
        #2 reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        last_pair = '0;
        repeat (3) @(negedge clk);
        push_slots('0, '0, 1'b0, 1);
        expect_frame('0, 1'b1);
        #2 reset_n = 1'b1;
        wait_cyc(15);
        check("bck_before_rise_2", I2S_BCK, 0);
        wait_cyc(16);
        check("bck_rise_2", I2S_BCK, 1);

        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("queue_drained", exp_q.size(), 0);
        check("stray_underrun", stray, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
